// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue_if
//  Description : Enqueue/dequeue handshake bundle between the fetch stage,
//                the fetch queue and the decode stage.
//                  enq_* : fetch side offers {pc, inst, target, pred}
//                  deq_* : queue presents its head entry to decode
//                Modport slave  : the queue's view (accepts enq, drives deq)
//                Modport master : the surrounding pipeline's view
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if #(
    parameter int DATA_W = 32
) ();

    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_pc;
    logic [DATA_W-1:0] enq_inst;
    logic [DATA_W-1:0] enq_target;
    logic              enq_pred;

    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_pc;
    logic [DATA_W-1:0] deq_inst;
    logic [DATA_W-1:0] deq_target;
    logic              deq_pred;

    modport slave (
        input  enq_valid, enq_pc, enq_inst, enq_target, enq_pred, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_inst, deq_target, deq_pred
    );

    modport master (
        output enq_valid, enq_pc, enq_inst, enq_target, enq_pred, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_inst, deq_target, deq_pred
    );

endinterface : if_fetch_queue_if
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue
//  Description : Instruction fetch queue between IF and ID. Circular buffer
//                of DEPTH entries {pc, inst, target, pred} with valid/ready
//                handshakes on both sides and a flush that empties it.
//  Ports       : clk    - clock, all state updates on rising edge
//                rst    - asynchronous active-high reset
//                flush  - redirect / mispredict, empties the queue
//                q_if   - if_fetch_queue_if.slave (enq_* in, deq_* out)
//                level  - current entry count, $clog2(DEPTH)+1 bits
//  Options     : `define FETCH_QUEUE_BYPASS_EN to let an entry offered to an
//                empty queue appear on deq_* in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    flush,
    if_fetch_queue_if.slave        q_if,
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    // ------------------------------------------------------------------
    // Parameter sanity: pointers wrap by natural overflow, so DEPTH must
    // be a power of two.
    // ------------------------------------------------------------------
    generate
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("if_fetch_queue: DEPTH must be a power of two in 2..16");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_LVL_W-1:0] r_level;

    // Storage has no reset; deq_* is forced to zero whenever the head is
    // not valid, so stale contents never leak out.
    logic [DATA_W-1:0]  r_mem_pc     [DEPTH];
    logic [DATA_W-1:0]  r_mem_inst   [DEPTH];
    logic [DATA_W-1:0]  r_mem_target [DEPTH];
    logic               r_mem_pred   [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_enq_ready;
    logic w_deq_valid;
    logic w_bypass;
    logic w_enq_fire;
    logic w_deq_fire;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_LVL_W'(DEPTH));
    // Depends only on the registered level, never on deq_ready.
    assign w_enq_ready = !w_full;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: the offered entry is presented straight to decode.
    assign w_bypass = w_empty && q_if.enq_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_deq_valid = w_bypass || (!w_empty && !flush);

    // A bypassed entry that decode takes is consumed without being
    // written; if decode stalls it is stored like any other entry.
    assign w_enq_fire = q_if.enq_valid && w_enq_ready && !flush
                        && !(w_bypass && q_if.deq_ready);

    // Storage is only popped when the head really came from storage.
    assign w_deq_fire = w_deq_valid && q_if.deq_ready && !w_bypass;

    // ------------------------------------------------------------------
    // Pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else if (flush) begin
            // Same-cycle enqueue and dequeue are discarded along with
            // everything already queued.
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_deq_fire) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            unique case ({w_enq_fire, w_deq_fire})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem_pc[r_tail]     <= q_if.enq_pc;
            r_mem_inst[r_tail]   <= q_if.enq_inst;
            r_mem_target[r_tail] <= q_if.enq_target;
            r_mem_pred[r_tail]   <= q_if.enq_pred;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------
    always_comb begin
        q_if.deq_pc     = '0;
        q_if.deq_inst   = '0;
        q_if.deq_target = '0;
        q_if.deq_pred   = 1'b0;
        if (w_bypass) begin
            q_if.deq_pc     = q_if.enq_pc;
            q_if.deq_inst   = q_if.enq_inst;
            q_if.deq_target = q_if.enq_target;
            q_if.deq_pred   = q_if.enq_pred;
        end else if (w_deq_valid) begin
            q_if.deq_pc     = r_mem_pc[r_head];
            q_if.deq_inst   = r_mem_inst[r_head];
            q_if.deq_target = r_mem_target[r_head];
            q_if.deq_pred   = r_mem_pred[r_head];
        end
    end

    assign q_if.enq_ready = w_enq_ready;
    assign q_if.deq_valid = w_deq_valid;
    assign level          = r_level;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_level_bound : assert property (@(posedge clk) disable iff (rst)
        r_level <= c_LVL_W'(DEPTH));

    a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
        r_tail == r_head + r_level[c_PTR_W-1:0]);

endmodule : if_fetch_queue
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_queue
//  Description : Self-checking bench for if_fetch_queue. Directed scenarios
//                (fill, full back-pressure, streaming across wrap, flush,
//                async reset, enqueue-to-dequeue latency) followed by
//                random traffic, all compared against a queue-based model.
//                Honours FETCH_QUEUE_BYPASS_EN when compiled with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] inst;
        logic [DW-1:0] target;
        logic          pred;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [LW-1:0] level;

    if_fetch_queue_if #(.DATA_W(DW)) bus ();

    if_fetch_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q_if  (bus.slave),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    ent_t q[$];
    logic exp_dv;
    logic exp_byp;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic [DW-1:0] pc, input logic [DW-1:0] inst,
                         input logic [DW-1:0] tgt, input logic pred,
                         input logic dr, input logic fl);
        bus.enq_valid  = ev;
        bus.enq_pc     = pc;
        bus.enq_inst   = inst;
        bus.enq_target = tgt;
        bus.enq_pred   = pred;
        bus.deq_ready  = dr;
        flush          = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare DUT outputs with what the model says for the current inputs.
    task automatic check_outputs();
        ent_t h;
        int   sz;
        sz      = q.size();
        exp_byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        exp_byp = (sz == 0) && bus.enq_valid && !flush;
`endif
        exp_dv = exp_byp || (sz != 0 && !flush);
        h = '0;
        if (exp_byp)
            h = '{pc: bus.enq_pc, inst: bus.enq_inst, target: bus.enq_target, pred: bus.enq_pred};
        else if (exp_dv)
            h = q[0];
        chk_eq("deq_valid",  bus.deq_valid,  exp_dv);
        chk_eq("enq_ready",  bus.enq_ready,  sz != DEPTH);
        chk_eq("level",      level,          sz);
        chk_eq("deq_pc",     bus.deq_pc,     h.pc);
        chk_eq("deq_inst",   bus.deq_inst,   h.inst);
        chk_eq("deq_target", bus.deq_target, h.target);
        chk_eq("deq_pred",   bus.deq_pred,   h.pred);
    endtask

    // Advance the model over the rising edge using the held inputs.
    task automatic update_model();
        logic deq_f, enq_f;
        int   sz;
        ent_t e;
        sz = q.size();
        if (flush) begin
            q.delete();
        end else begin
            deq_f = exp_dv && bus.deq_ready;
            enq_f = bus.enq_valid && (sz < DEPTH);
            e = '{pc: bus.enq_pc, inst: bus.enq_inst, target: bus.enq_target, pred: bus.enq_pred};
            if (!(exp_byp && deq_f)) begin
                if (deq_f) void'(q.pop_front());
                if (enq_f) q.push_back(e);
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic finish_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic dcycle(input logic ev, input logic [DW-1:0] pc, input logic dr, input logic fl);
        drive(ev, pc, pc ^ 32'hA5A5_0000, pc + 32'h100, pc[2], dr, fl);
        finish_cycle();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) dcycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #3;
        chk_eq("rst_deq_valid", bus.deq_valid, 1'b0);
        chk_eq("rst_enq_ready", bus.enq_ready, 1'b1);
        chk_eq("rst_level",     level,         0);
        chk_eq("rst_deq_pc",    bus.deq_pc,    0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) dcycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
        chk_eq("fill_level",     level,         4);
        chk_eq("fill_enq_ready", bus.enq_ready, 1'b0);
        chk_eq("fill_deq_pc",    bus.deq_pc,    32'h0);
        chk_eq("fill_deq_inst",  bus.deq_inst,  32'hA5A5_0000);

        // Offer while full: must be dropped.
        for (int i = 0; i < 3; i++) dcycle(1'b1, 32'h10, 1'b0, 1'b0);
        chk_eq("full_level", level, 4);
        drain(4);
        chk_eq("drained_valid", bus.deq_valid, 1'b0);

        // Streaming at level 2 across pointer wrap.
        dcycle(1'b1, 32'h0, 1'b0, 1'b0);
        dcycle(1'b1, 32'h4, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk_eq("stream_pc", bus.deq_pc, 32'(4 * i));
            dcycle(1'b1, 32'(8 + 4 * i), 1'b1, 1'b0);
            chk_eq("stream_level", level, 2);
        end
        drain(2);

        // Flush together with an enqueue.
        for (int i = 0; i < 3; i++) dcycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
        dcycle(1'b1, 32'h40, 1'b0, 1'b1);
        idle();
        #1;
        chk_eq("flush_level", level,         0);
        chk_eq("flush_valid", bus.deq_valid, 1'b0);
        dcycle(1'b1, 32'h80, 1'b0, 1'b0);
        idle();
        #1;
        chk_eq("post_flush_valid", bus.deq_valid, 1'b1);
        chk_eq("post_flush_pc",    bus.deq_pc,    32'h80);
        drain(1);

        // Asynchronous reset in the middle of a cycle.
        dcycle(1'b1, 32'h300, 1'b0, 1'b0);
        dcycle(1'b1, 32'h304, 1'b0, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk_eq("arst_deq_valid", bus.deq_valid, 1'b0);
        chk_eq("arst_level",     level,         0);
        chk_eq("arst_enq_ready", bus.enq_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dcycle(1'b1, 32'h200, 1'b0, 1'b0);
        dcycle(1'b1, 32'h204, 1'b0, 1'b0);
        chk_eq("arst_first_pc", bus.deq_pc, 32'h200);
        drain(2);

        // Enqueue-to-dequeue latency on an empty queue.
        drive(1'b1, 32'h100, 32'h1234_5678, 32'h104, 1'b1, 1'b1, 1'b0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk_eq("lat_same_valid", bus.deq_valid, 1'b1);
        chk_eq("lat_same_pc",    bus.deq_pc,    32'h100);
`else
        chk_eq("lat_same_valid", bus.deq_valid, 1'b0);
`endif
        chk_eq("lat_same_level", level, 0);
        finish_cycle();
        idle();
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk_eq("lat_next_valid", bus.deq_valid, 1'b0);
        chk_eq("lat_next_level", level,         0);
`else
        chk_eq("lat_next_valid", bus.deq_valid, 1'b1);
        chk_eq("lat_next_pc",    bus.deq_pc,    32'h100);
        chk_eq("lat_next_level", level,         1);
`endif
        drain(1);

        // Random traffic: fill-biased, then drain-biased, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 200; i++) begin
                logic ev, dr, fl;
                ev = (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                dr = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
                fl = ($urandom_range(0, 24) == 0);
                drive(ev, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), dr, fl);
                finish_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_if_fetch_queue
`default_nettype wire

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter DATA_W, 32, width of PC, instruction and target fields.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port flush, input, 1, redirect/predict-fail; empties the queue.
REQ-006 Port enq_valid, input, 1, fetch side offers an entry.
REQ-007 Port enq_ready, output, 1, queue can accept an entry.
REQ-008 Port enq_pc / enq_inst / enq_target, input, DATA_W each, fetched PC, instruction, predicted next PC.
REQ-009 Port enq_pred, input, 1, branch-predictor taken flag.
REQ-010 Port deq_valid, output, 1, head entry presented to decode.
REQ-011 Port deq_ready, input, 1, decode accepts the head entry (low while ID stalls).
REQ-012 Port deq_pc / deq_inst / deq_target, output, DATA_W each; deq_pred, output, 1; head entry fields.
REQ-013 Port level, output, $clog2(DEPTH)+1, current entry count.

Function
REQ-014 Storage: circular buffer of DEPTH entries {pc, inst, target, pred}; head and tail pointers wrap modulo DEPTH.
REQ-015 Enqueue fire = enq_valid && enq_ready && !flush; entry written at tail, tail advances by one.
REQ-016 Dequeue fire = deq_valid && deq_ready; head advances by one.
REQ-017 enq_ready = (level != DEPTH); it does not depend combinationally on deq_ready.
REQ-018 deq_valid = (level != 0) && !flush when not bypassing.
REQ-019 When deq_valid is 0, all deq_* data outputs drive zero.
REQ-020 level next = level + enq fire - deq fire; simultaneous enqueue and dequeue leaves level unchanged and is legal at any non-full level.
REQ-021 Head fields stay stable while deq_valid && !deq_ready; FIFO order is strictly preserved.
REQ-022 Flush: at the edge with flush=1, head, tail and level go to 0; the same-cycle enqueue and dequeue are discarded.
REQ-023 enq_valid while enq_ready=0 is ignored, with no state change; deq_ready while deq_valid=0 is ignored.
REQ-024 Minimum latency enqueue-to-deq_valid is 1 cycle (bypass disabled).

Reset
REQ-025 On rst=1, head, tail and level clear to 0 immediately, regardless of clk.
REQ-026 During reset, deq_valid=0, deq_* data=0, enq_ready=1, and level=0.
REQ-027 Reset asserted mid-transfer drops all entries; no entry reappears after release.
REQ-028 Storage array contents are not reset; their content is unobservable because of REQ-019.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN: when defined, if level==0, enq_valid=1 and flush=0, deq_valid=1 and deq_* equal enq_* in the same cycle.
REQ-030 With the macro defined, a bypassed entry accepted by deq_ready is not written; if deq_ready=0, it is enqueued normally.
REQ-031 Without the macro, there is no combinational path from enq_* to deq_*, and REQ-024 applies.

Verification
REQ-032 Reset, then push PC 0x0,0x4,0x8,0xC with deq_ready=0 -> level=4, enq_ready=0, deq_pc=0x0, deq_inst equals first instruction.
REQ-033 Full queue (DEPTH=4), enq_valid=1 with PC 0x10, deq_ready=0 for 3 cycles -> PC 0x10 never stored, level stays 4.
REQ-034 Continuous enq and deq at level 2 for 10 cycles across pointer wrap -> level stays 2, PCs emerge in order 0x0..0x24 step 4.
REQ-035 Level 3, assert flush together with enq_valid (PC 0x40) -> next cycle level=0, deq_valid=0; then push 0x80 -> deq_pc=0x80 after one cycle.
REQ-036 Assert rst asynchronously mid-cycle at level 2 -> deq_valid falls without a clock edge, level=0; after release, the first pushed PC is the first popped.
REQ-037 Bypass build, empty queue, enq PC 0x100 with deq_ready=1 -> deq_valid=1, deq_pc=0x100 in the same cycle, level stays 0; non-bypass build -> deq_valid rises the next cycle.
